// File: rtl/affine_engine_if.sv
// Streaming and configuration bundle for affine_engine.
//
// Handshake semantics: a transfer happens on a rising clock edge where both
// valid and ready are high. The producer holds valid and its data stable
// until that edge. The consumer may change ready at any time. in_ready and
// out_valid are registered, so neither one depends combinationally on its
// partner signal.
interface affine_engine_if #(
    parameter int W  = 8,
    parameter int CW = 8
);
    localparam int DW = (W > CW) ? W : CW;

    // Input stream: producer -> engine
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  x1;
    logic signed [W-1:0]  y1;

    // Result stream: engine -> consumer
    logic                 out_valid;
    logic                 out_ready;
    logic signed [W-1:0]  x2;
    logic signed [W-1:0]  y2;

    // Coefficient and offset programming
    logic                 cfg_we;
    logic [2:0]           cfg_addr;
    logic [DW-1:0]        cfg_data;
    logic                 cfg_err;

    modport master (
        output in_valid, x1, y1, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, x2, y2, cfg_err
    );

    modport slave (
        input  in_valid, x1, y1, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, x2, y2, cfg_err
    );
endinterface

// File: rtl/affine_engine.sv
// affine_engine: x2 = a*x1 + b*y1 + e, y2 = c*x1 + d*y1 + f.
// Coefficients a..d are signed fixed point with FRAC fraction bits; e/f are
// plain signed integers. One W x CW multiplier is time-shared over four MAC
// states. The reset coefficient set reproduces the legacy picoMips transform
// (0.75, 0.5, -0.5, 0.75, +20, -20). FRAC must lie in [2, CW-2].
module affine_engine #(
    parameter int W        = 8,
    parameter int CW       = 8,
    parameter int FRAC     = 6,
    parameter int SATURATE = 1
) (
    input  logic           Clock,
    input  logic           nReset,
    affine_engine_if.slave bus,
    output logic [2:0]     dbg_state
);
    localparam int PW = W + CW;      // raw product width
    localparam int AW = W + CW + 2;  // accumulator width

    localparam logic signed [CW-1:0] A_RST = CW'(3 << (FRAC - 2));
    localparam logic signed [CW-1:0] B_RST = CW'(1 << (FRAC - 1));
    localparam logic signed [CW-1:0] C_RST = CW'(-(1 << (FRAC - 1)));
    localparam logic signed [CW-1:0] D_RST = CW'(3 << (FRAC - 2));
    localparam logic signed [W-1:0]  E_RST = W'(20);
    localparam logic signed [W-1:0]  F_RST = W'(-20);

    // Output range limits, sign-extended to accumulator width
    localparam logic signed [AW-1:0] MAX_V = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MAC_AX = 3'd1,
        MAC_BY = 3'd2,
        MAC_CX = 3'd3,
        MAC_DY = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state;

    // Programmable coefficients and offsets
    logic signed [CW-1:0] coef_a, coef_b, coef_c, coef_d;
    logic signed [W-1:0]  off_e, off_f;

    // Datapath registers
    logic signed [W-1:0]  x_r, y_r;
    logic signed [AW-1:0] acc;
    logic signed [W-1:0]  rx_r;
    logic signed [W-1:0]  x2_r, y2_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 cfg_err_r;

    // Shared multiplier operands and post-MAC arithmetic
    logic signed [W-1:0]  mul_op;
    logic signed [CW-1:0] mul_coef;
    logic signed [W-1:0]  off_sel;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] sum_w;
    logic signed [AW-1:0] shr_w;
    logic signed [AW-1:0] off_ext;
    logic signed [AW-1:0] res_w;
    logic signed [W-1:0]  result;
    logic                 cfg_ok;

    // Clamp or wrap a full-width result into W bits
    function automatic logic signed [W-1:0] fit(input logic signed [AW-1:0] v);
        logic signed [W-1:0] r;
        r = v[W-1:0];
        if (SATURATE != 0) begin
            if (v > MAX_V)
                r = MAX_V[W-1:0];
            else if (v < MIN_V)
                r = MIN_V[W-1:0];
        end
        return r;
    endfunction

    // Select multiplier operand, coefficient and offset for the current MAC step
    always_comb begin
        mul_op   = x_r;
        mul_coef = coef_a;
        off_sel  = off_e;
        case (state)
            MAC_BY: begin
                mul_op   = y_r;
                mul_coef = coef_b;
            end
            MAC_CX: begin
                mul_op   = x_r;
                mul_coef = coef_c;
                off_sel  = off_f;
            end
            MAC_DY: begin
                mul_op   = y_r;
                mul_coef = coef_d;
                off_sel  = off_f;
            end
            default: ;
        endcase
    end

    assign prod     = mul_op * mul_coef;
    assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
    assign sum_w    = acc + prod_ext;
    // Arithmetic shift: floor rounding of the fixed-point sum
    assign shr_w    = sum_w >>> FRAC;
    assign off_ext  = {{(AW-W){off_sel[W-1]}}, off_sel};
    assign res_w    = shr_w + off_ext;
    assign result   = fit(res_w);

    // Writes land only while idle and only to addresses 0..5
    assign cfg_ok = bus.cfg_we && (state == IDLE) && (bus.cfg_addr <= 3'd5);

    // Coefficient/offset registers and the write-rejected pulse
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            coef_a    <= A_RST;
            coef_b    <= B_RST;
            coef_c    <= C_RST;
            coef_d    <= D_RST;
            off_e     <= E_RST;
            off_f     <= F_RST;
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= bus.cfg_we && !cfg_ok;
            if (cfg_ok) begin
                case (bus.cfg_addr)
                    3'd0:    coef_a <= bus.cfg_data[CW-1:0];
                    3'd1:    coef_b <= bus.cfg_data[CW-1:0];
                    3'd2:    coef_c <= bus.cfg_data[CW-1:0];
                    3'd3:    coef_d <= bus.cfg_data[CW-1:0];
                    3'd4:    off_e  <= bus.cfg_data[W-1:0];
                    3'd5:    off_f  <= bus.cfg_data[W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Sequencer: accept, four MAC steps, hold result until consumed
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            x_r         <= '0;
            y_r         <= '0;
            acc         <= '0;
            rx_r        <= '0;
            x2_r        <= '0;
            y2_r        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (bus.in_valid && in_ready_r) begin
                        x_r        <= bus.x1;
                        y_r        <= bus.y1;
                        in_ready_r <= 1'b0;
                        state      <= MAC_AX;
                    end
                end
                MAC_AX: begin
                    acc   <= prod_ext;
                    state <= MAC_BY;
                end
                MAC_BY: begin
                    acc   <= sum_w;
                    rx_r  <= result;
                    state <= MAC_CX;
                end
                MAC_CX: begin
                    acc   <= prod_ext;
                    state <= MAC_DY;
                end
                MAC_DY: begin
                    // Both results are published together with out_valid
                    acc         <= sum_w;
                    x2_r        <= rx_r;
                    y2_r        <= result;
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.x2        = x2_r;
    assign bus.y2        = y2_r;
    assign bus.cfg_err   = cfg_err_r;
    assign dbg_state     = state;

endmodule

// File: tb/tb_affine_engine.sv
// Directed bench for affine_engine. A saturating and a wrapping instance are
// driven in lockstep; every expected value below is hand-computed.
module tb_affine_engine;
    localparam int W  = 8;
    localparam int CW = 8;

    logic       Clock;
    logic       nReset;
    logic [2:0] dbg_state;
    logic [2:0] dbg_state_w;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    affine_engine_if #(.W(W), .CW(CW)) bus ();
    affine_engine_if #(.W(W), .CW(CW)) wbus ();

    affine_engine #(.W(W), .CW(CW), .FRAC(6), .SATURATE(1)) u_sat (
        .Clock     (Clock),
        .nReset    (nReset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    affine_engine #(.W(W), .CW(CW), .FRAC(6), .SATURATE(0)) u_wrap (
        .Clock     (Clock),
        .nReset    (nReset),
        .bus       (wbus.slave),
        .dbg_state (dbg_state_w)
    );

    // Wrapping instance sees exactly the same stimulus
    assign wbus.in_valid  = bus.in_valid;
    assign wbus.x1        = bus.x1;
    assign wbus.y1        = bus.y1;
    assign wbus.out_ready = bus.out_ready;
    assign wbus.cfg_we    = bus.cfg_we;
    assign wbus.cfg_addr  = bus.cfg_addr;
    assign wbus.cfg_data  = bus.cfg_data;

    // Clock and cycle counter
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic accept(input int x, input int y, output int at);
        int n;
        bus.x1       = W'(x);
        bus.y1       = W'(y);
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 20) chk("in_ready_timeout", bus.in_ready, 1);
        @(posedge Clock);
        at = cyc;
        @(negedge Clock);
        bus.in_valid = 1'b0;
    endtask

    // Counts cycles after the accepting edge until out_valid is seen
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge Clock);
            lat++;
        end
    endtask

    task automatic do_txn(input string tag, input int x, input int y,
                          input int ex, input int ey, input int ewx,
                          input int ewy, output int at);
        int lat;
        bus.out_ready = 1'b1;
        accept(x, y, at);
        wait_valid(lat);
        chk($sformatf("%s_latency", tag), lat, 5);
        chk($sformatf("%s_x2", tag), bus.x2, ex);
        chk($sformatf("%s_y2", tag), bus.y2, ey);
        chk($sformatf("%s_wrap_x2", tag), wbus.x2, ewx);
        chk($sformatf("%s_wrap_y2", tag), wbus.y2, ewy);
        @(negedge Clock);
        chk($sformatf("%s_out_valid_drop", tag), bus.out_valid, 0);
        chk($sformatf("%s_in_ready_back", tag), bus.in_ready, 1);
    endtask

    task automatic cfg_write(input int addr, input int data, output logic err);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'(addr);
        bus.cfg_data = 8'(data);
        @(posedge Clock);
        @(negedge Clock);
        bus.cfg_we = 1'b0;
        err = bus.cfg_err;
    endtask

    initial begin
        int   at0, at1, at2, lat, n;
        logic err;

        bus.in_valid  = 1'b0;
        bus.x1        = '0;
        bus.y1        = '0;
        bus.out_ready = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        nReset        = 1'b0;

        // Reset state
        #3;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_x2", bus.x2, 0);
        chk("rst_y2", bus.y2, 0);
        chk("rst_cfg_err", bus.cfg_err, 0);
        chk("rst_state", dbg_state, 0);
        @(negedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
        #1;
        chk("release_in_ready_low", bus.in_ready, 0);
        @(negedge Clock);
        chk("release_in_ready_high", bus.in_ready, 1);

        // Default coefficients, back-to-back with out_ready high
        do_txn("def_4_6", 4, 6, 26, -18, 26, -18, at0);
        do_txn("def_40_21", 40, 21, 60, -25, 60, -25, at1);
        chk("b2b_spacing_1", at1 - at0, 6);
        do_txn("def_20_55", 20, 55, 62, 11, 62, 11, at2);
        chk("b2b_spacing_2", at2 - at1, 6);

        // Overflow: saturate vs wrap
        do_txn("ovf_100_100", 100, 100, 127, 5, -111, 5, at0);

        // Back-pressure
        bus.out_ready = 1'b0;
        accept(40, 21, at0);
        wait_valid(lat);
        chk("bp_latency", lat, 5);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.x1       = 8'sd99;
            bus.y1       = -8'sd99;
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_x2", bus.x2, 60);
            chk("bp_y2", bus.y2, -25);
            chk("bp_in_ready", bus.in_ready, 0);
            @(negedge Clock);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge Clock);
        chk("bp_release_out_valid", bus.out_valid, 0);
        chk("bp_release_in_ready", bus.in_ready, 1);
        chk("bp_hold_x2", bus.x2, 60);
        chk("bp_hold_y2", bus.y2, -25);
        chk("bp_idle_state", dbg_state, 0);

        // Identity transform
        cfg_write(0, 64, err);  chk("cfg_a_err", err, 0);
        cfg_write(1, 0, err);   chk("cfg_b_err", err, 0);
        cfg_write(4, 0, err);   chk("cfg_e_err", err, 0);
        cfg_write(2, 0, err);   chk("cfg_c_err", err, 0);
        cfg_write(3, 64, err);  chk("cfg_d_err", err, 0);
        cfg_write(5, 0, err);   chk("cfg_f_err", err, 0);
        do_txn("id_m128_127", -128, 127, -128, 127, -128, 127, at0);

        // Write to a while busy is rejected
        bus.out_ready = 1'b0;
        accept(4, 6, at0);
        @(posedge Clock);
        @(negedge Clock);
        chk("busy_state_mac_by", dbg_state, 2);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd0;
        bus.cfg_data = 8'd0;
        @(posedge Clock);
        @(negedge Clock);
        bus.cfg_we = 1'b0;
        chk("busy_cfg_err_pulse", bus.cfg_err, 1);
        @(negedge Clock);
        chk("busy_cfg_err_clear", bus.cfg_err, 0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge Clock);
            n++;
        end
        chk("busy_out_valid", bus.out_valid, 1);
        chk("busy_x2", bus.x2, 4);
        chk("busy_y2", bus.y2, 6);
        bus.out_ready = 1'b1;
        @(negedge Clock);
        do_txn("busy_a_kept", 4, 6, 4, 6, 4, 6, at0);

        // Write to address 6 is rejected
        cfg_write(6, 17, err);
        chk("addr6_cfg_err", err, 1);
        do_txn("addr6_no_alias", -5, 9, -5, 9, -5, 9, at0);

        // Asynchronous reset during MAC_CX
        accept(40, 21, at0);
        @(posedge Clock);
        @(posedge Clock);
        @(negedge Clock);
        chk("abort_state_mac_cx", dbg_state, 3);
        #1;
        nReset = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_x2", bus.x2, 0);
        chk("abort_y2", bus.y2, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_state", dbg_state, 0);
        @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);
        chk("abort_release_in_ready", bus.in_ready, 1);
        do_txn("post_reset_4_6", 4, 6, 26, -18, 26, -18, at0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
